// File: rtl/token_pkg.sv
// Shared types and default widths for the token coalescer.
package token_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_OFFER   = 2'd2
  } state_e;

  localparam int DEF_CNT_WIDTH = 8;
  localparam int DEF_TMO_WIDTH = 8;

endpackage

// File: rtl/token_coalescer.sv
// Drains a dataless token FIFO and groups the tokens into batches.
// Batches close on size or timeout and are offered downstream with valid/ready.
module token_coalescer
  import token_pkg::*;
#(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int TMO_WIDTH = DEF_TMO_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CLR,
  input  logic                 FIFO_EMPTY_N,
  output logic                 FIFO_DEQ,
  input  logic [CNT_WIDTH-1:0] CFG_BATCH,
  input  logic [TMO_WIDTH-1:0] CFG_TIMEOUT,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [CNT_WIDTH-1:0] OUT_COUNT
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [TMO_WIDTH-1:0] TMO_ZERO = {TMO_WIDTH{1'b0}};
  localparam logic [TMO_WIDTH-1:0] TMO_ONE  = {{(TMO_WIDTH-1){1'b0}}, 1'b1};

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic [TMO_WIDTH-1:0]   timer_q, timer_d;
  logic                   out_valid_q, out_valid_d;
  logic [CNT_WIDTH-1:0]   out_count_q, out_count_d;
  logic [CNT_WIDTH-1:0]   eff_batch_s;
  logic [TMO_WIDTH-1:0]   timer_inc_s;
  logic                   deq_s;

  assign deq_s       = RST & ~CLR & FIFO_EMPTY_N & (state_q != ST_OFFER);
  assign FIFO_DEQ    = deq_s;
  assign OUT_VALID   = out_valid_q;
  assign OUT_COUNT   = out_count_q;
  assign eff_batch_s = (CFG_BATCH == CNT_ZERO) ? CNT_ONE : CFG_BATCH;
  // Saturating so a disabled timeout never wraps into a spurious match.
  assign timer_inc_s = (&timer_q) ? timer_q : (timer_q + TMO_ONE);

  // Next-state, counter, timer and registered-output logic.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    timer_d = timer_q;
    case (state_q)
      ST_IDLE: begin
        if (deq_s) begin
          count_d = CNT_ONE;
          timer_d = TMO_ZERO;
          state_d = (eff_batch_s == CNT_ONE) ? ST_OFFER : ST_COLLECT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        timer_d = timer_inc_s;
        count_d = count_q + {{(CNT_WIDTH-1){1'b0}}, deq_s};
        // >= so that lowering CFG_BATCH mid-batch still closes it.
        if (count_d >= eff_batch_s) begin
          state_d = ST_OFFER;
        end else if ((CFG_TIMEOUT != TMO_ZERO) && (timer_d == CFG_TIMEOUT)) begin
          state_d = ST_OFFER;
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_OFFER: begin
        if (OUT_READY) begin
          count_d = CNT_ZERO;
          timer_d = TMO_ZERO;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OFFER;
        end
      end
      default: begin
        count_d = CNT_ZERO;
        timer_d = TMO_ZERO;
        state_d = ST_IDLE;
      end
    endcase
    if (CLR) begin
      count_d = CNT_ZERO;
      timer_d = TMO_ZERO;
      state_d = ST_IDLE;
    end else begin
      state_d = state_d;
    end
    out_valid_d = (state_d == ST_OFFER);
    out_count_d = out_valid_d ? count_d : CNT_ZERO;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      count_q     <= CNT_ZERO;
      timer_q     <= TMO_ZERO;
      out_valid_q <= 1'b0;
      out_count_q <= CNT_ZERO;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      timer_q     <= timer_d;
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
    end
  end

endmodule

// File: tb/tb_token_coalescer.sv
// Directed self-checking bench for token_coalescer.
module tb_token_coalescer;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       empty_n;
  logic       deq;
  logic [7:0] cfg_batch;
  logic [7:0] cfg_timeout;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_count;

  int n_tests = 0;
  int n_fail  = 0;
  int underflow_cnt = 0;

  token_coalescer #(.CNT_WIDTH(8), .TMO_WIDTH(8)) dut (
    .CLK          (clk),
    .RST          (rst),
    .CLR          (clr),
    .FIFO_EMPTY_N (empty_n),
    .FIFO_DEQ     (deq),
    .CFG_BATCH    (cfg_batch),
    .CFG_TIMEOUT  (cfg_timeout),
    .OUT_VALID    (out_valid),
    .OUT_READY    (out_ready),
    .OUT_COUNT    (out_count)
  );

  always #5 clk = ~clk;

  // Upstream FIFO would flag an underflow on a dequeue while empty.
  always @(posedge clk) begin
    if (rst && deq && !empty_n) underflow_cnt <= underflow_cnt + 1;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cleanup();
    empty_n   = 1'b0;
    out_ready = 1'b1;
    clr       = 1'b1;
    next_cycle();
    clr       = 1'b0;
  endtask

  logic [9:0] exp_deq;
  logic [9:0] exp_valid;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; clr = 1'b0; empty_n = 1'b1; out_ready = 1'b0;
    cfg_batch = 8'd4; cfg_timeout = 8'd0;
    next_cycle();
    next_cycle();
    #1;
    check_eq("rst_deq",   int'(deq), 0);
    check_eq("rst_valid", int'(out_valid), 0);
    check_eq("rst_count", int'(out_count), 0);

    // Batch close at 4 with continuous tokens.
    rst = 1'b1; out_ready = 1'b1;
    exp_deq   = 10'b0111101111;
    exp_valid = 10'b1000010000;
    for (int c = 0; c < 10; c++) begin
      #1;
      check_eq($sformatf("b4_deq_c%0d", c), int'(deq), int'(exp_deq[c]));
      check_eq($sformatf("b4_valid_c%0d", c), int'(out_valid), int'(exp_valid[c]));
      if (exp_valid[c]) check_eq($sformatf("b4_count_c%0d", c), int'(out_count), 4);
      next_cycle();
    end
    cleanup();

    // Timeout close after a single token, then backpressure.
    cfg_batch = 8'd8; cfg_timeout = 8'd5; out_ready = 1'b0; empty_n = 1'b1;
    #1;
    check_eq("tmo_deq_c0", int'(deq), 1);
    next_cycle();
    empty_n = 1'b0;
    for (int c = 1; c < 6; c++) begin
      #1;
      check_eq($sformatf("tmo_valid_c%0d", c), int'(out_valid), 0);
      next_cycle();
    end
    empty_n = 1'b1;
    for (int c = 6; c < 16; c++) begin
      #1;
      check_eq($sformatf("bp_valid_c%0d", c), int'(out_valid), 1);
      check_eq($sformatf("bp_count_c%0d", c), int'(out_count), 1);
      check_eq($sformatf("bp_deq_c%0d", c), int'(deq), 0);
      next_cycle();
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_hs_valid", int'(out_valid), 1);
    check_eq("bp_hs_deq", int'(deq), 0);
    next_cycle();
    #1;
    check_eq("bp_after_valid", int'(out_valid), 0);
    check_eq("bp_after_deq", int'(deq), 1);
    cleanup();

    // CLR in COLLECT after 3 tokens drops them.
    cfg_batch = 8'd8; cfg_timeout = 8'd0; empty_n = 1'b1;
    next_cycle();
    next_cycle();
    next_cycle();
    clr = 1'b1;
    #1;
    check_eq("clr_deq", int'(deq), 0);
    next_cycle();
    clr = 1'b0; empty_n = 1'b1; cfg_batch = 8'd2;
    #1;
    check_eq("clr_valid_c4", int'(out_valid), 0);
    check_eq("clr_deq_c4", int'(deq), 1);
    next_cycle();
    #1;
    check_eq("clr_valid_c5", int'(out_valid), 0);
    next_cycle();
    empty_n = 1'b0;
    #1;
    check_eq("clr_valid_c6", int'(out_valid), 1);
    check_eq("clr_count_c6", int'(out_count), 2);
    cleanup();

    // Reset in the middle of an offer.
    cfg_batch = 8'd4; cfg_timeout = 8'd0; out_ready = 1'b0; empty_n = 1'b1;
    for (int c = 0; c < 4; c++) next_cycle();
    #1;
    check_eq("rsto_valid", int'(out_valid), 1);
    check_eq("rsto_count", int'(out_count), 4);
    rst = 1'b0;
    #1;
    check_eq("rsto_deq_low", int'(deq), 0);
    next_cycle();
    #1;
    check_eq("rsto_valid_after", int'(out_valid), 0);
    check_eq("rsto_count_after", int'(out_count), 0);
    check_eq("rsto_deq_after", int'(deq), 0);
    next_cycle();
    rst = 1'b1; out_ready = 1'b1; cfg_timeout = 8'd2;
    next_cycle();
    empty_n = 1'b0;
    next_cycle();
    #1;
    check_eq("rsto_new_c8_valid", int'(out_valid), 0);
    next_cycle();
    #1;
    check_eq("rsto_new_valid", int'(out_valid), 1);
    check_eq("rsto_new_count", int'(out_count), 1);
    cleanup();

    // CFG_BATCH=0 behaves as 1: every token is its own batch.
    cfg_batch = 8'd0; cfg_timeout = 8'd0; out_ready = 1'b1; empty_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      check_eq($sformatf("b0_deq_c%0d", c), int'(deq), (c % 2 == 0) ? 1 : 0);
      check_eq($sformatf("b0_valid_c%0d", c), int'(out_valid), (c % 2 == 1) ? 1 : 0);
      if (c % 2 == 1) check_eq($sformatf("b0_count_c%0d", c), int'(out_count), 1);
      next_cycle();
    end
    cleanup();

    check_eq("no_underflow", underflow_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
